vq_stream_codec: RTL and testbench
==================================

Name: vq_stream_codec

Overview:
- Streaming block-wise vector quantizer. Successor to the fixed 32-to-8-bit quantize/dequantize pair, generalised in input width, code width and vector length.
- Collects one vector of VEC_LEN signed samples and finds its absolute maximum. It then picks a per-vector power-of-two scale (shift) and emits rounded, saturated Q_W-bit codes with valid/ready backpressure.
- Sits between the sample source and the compressed-tensor store; the optional path also emits dequantized samples.

Parameters:
- DIN_W, 32, signed input sample width (>= Q_W+1)
- Q_W, 8, signed code width; QMAX = 2^(Q_W-1)-1
- VEC_LEN, 16, samples per vector (>= 2); one scale per vector
- SH_W, $clog2(DIN_W+1), width of shift field

Ports:
- clk_i  in  1  clock, rising edge
- rstn_i  in  1  asynchronous active-low reset
- in_valid_i  in  1  input sample valid
- in_ready_o  out  1  block accepts input sample
- din_i  in  DIN_W  signed input sample
- out_valid_o  out  1  output code valid
- out_ready_i  in  1  downstream accepts code
- qout_o  out  Q_W  signed quantized code
- shift_o  out  SH_W  vector scale exponent (scale = 2^shift)
- dq_o  out  DIN_W  dequantized sample (see optional feature)
- out_last_o  out  1  marks the final code of the vector
- done_o  out  1  one-cycle pulse after the last code is accepted
- busy_o  out  1  high in any state except IDLE

Behaviour:
- Reset (async, rstn_i low): state = IDLE, counters and absmax = 0.
  - Outputs: in_ready_o=0, out_valid_o=0, qout_o=0, shift_o=0, dq_o=0, out_last_o=0, done_o=0, busy_o=0.
  - Buffer contents are don't-care.
- States: IDLE -> LOAD -> SCALE -> EMIT -> IDLE.
- IDLE: in_ready_o=0. Moves to LOAD the next cycle, unconditionally; IDLE is a single-cycle breather.
- LOAD: in_ready_o=1.
  - Each handshake (in_valid_i & in_ready_o) writes din_i to buf[idx], idx++.
  - absmax updates to max(absmax, |din_i|). The magnitude is computed as DIN_W-bit unsigned, so |-2^(DIN_W-1)| = 2^(DIN_W-1) is exact.
  - After handshake number VEC_LEN: go to SCALE and clear idx. in_ready_o drops in the same cycle the state leaves LOAD.
- SCALE: shift starts at 0 and increments once per cycle while (absmax >> shift) > QMAX. When the condition fails, register shift and go to EMIT. Latency is shift+1 cycles.
- EMIT: buf[idx] is presented combinationally.
  - Rounding: r = (x + (shift>0 ? 2^(shift-1) : 0)) >>> shift. Round half toward +inf; use a DIN_W+1 intermediate so the add cannot overflow.
  - Saturation: qout_o = clamp(r, -QMAX-1, QMAX).
  - out_valid_o=1 and shift_o holds for the whole vector.
  - Hold rule: outputs are held stable while out_valid_o & !out_ready_i. idx advances only on handshake.
  - out_last_o = (idx == VEC_LEN-1).
  - On the last handshake: done_o pulses the next cycle, state returns to IDLE, absmax is cleared.
- Throughput: one sample per cycle in LOAD and EMIT. Input and output phases do not overlap; a single buffer is used.
- Boundary conditions:
  - All-zero vector gives shift=0 and all codes 0.
  - in_valid_i gaps stall LOAD with no timeout.
  - out_ready_i held low stalls EMIT indefinitely.
  - rstn_i asserted mid-vector discards the partial vector; no done_o.

Optional Feature:
- Macro VQ_DEQUANT_EN.
- Defined: dq_o = sign_extend(qout_o) <<< shift_o, valid with out_valid_o.
- Undefined: dq_o tied to 0 and no dequant logic is synthesised. Port list is unchanged in both cases.

Decomposition:
- Package vq_pkg holds:
  - state enum (IDLE, LOAD, SCALE, EMIT)
  - function computing QMAX from Q_W
  - function computing the SH_W default
- Natural sub-module: vq_round_sat. It is combinational and takes (x, shift) to produce a saturated Q_W code. It is reused by the bench reference model.

Test Plan (DIN_W=32, Q_W=8, VEC_LEN=16):
- In-range vector: values -127..127 incl. 0 -> shift=0, codes equal inputs; done_o pulses once one cycle after the last handshake.
- Scaled vector: absmax=1000 with samples {1000, -1000, 12, 3} -> shift=3, codes {125, -125, 2, 0}; dq_o (VQ_DEQUANT_EN) = {1000, -1000, 16, 0}.
- Saturation: absmax=1020 -> shift=3; 1020 -> (1024>>3)=128 -> code 127. Sample -2^31 -> shift=25, code -64.
- Backpressure: out_ready_i toggled 1,0,0,1 randomly -> qout_o, out_last_o and shift_o stable while stalled; exactly 16 handshakes; out_last_o only on the 16th.
- Input gaps: in_valid_i with random bubbles -> in_ready_o high only in LOAD; codes identical to the no-gap run.
- Reset mid-operation: rstn_i pulsed after 7 inputs -> all outputs 0 immediately, no done_o; the next full vector is processed correctly.

Source files
------------

// File: rtl/vq_pkg.sv
// Shared types and parameter helpers for the vq_stream_codec vector quantizer.
package vq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SCALE = 2'd2,
        EMIT  = 2'd3
    } vq_state_e;

    function automatic int qmax(input int q_w);
        return (1 << (q_w - 1)) - 1;
    endfunction

    function automatic int sh_w_default(input int din_w);
        return $clog2(din_w + 1);
    endfunction

endpackage

// File: rtl/vq_round_sat.sv
// Rounds x / 2^shift half toward +inf and clamps the result to a signed Q_W-bit code.
module vq_round_sat
    import vq_pkg::*;
#(
    parameter int DIN_W = 32,
    parameter int Q_W   = 8,
    parameter int SH_W  = sh_w_default(DIN_W)
) (
    input  logic signed [DIN_W-1:0] x,
    input  logic        [SH_W-1:0]  shift,
    output logic signed [Q_W-1:0]   q
);

    localparam logic signed [DIN_W:0] QMAX_X = (DIN_W+1)'(qmax(Q_W));
    localparam logic signed [DIN_W:0] QMIN_X = (DIN_W+1)'(-qmax(Q_W) - 1);

    logic signed [DIN_W:0] x_ext;
    logic signed [DIN_W:0] bias;
    logic signed [DIN_W:0] sum;
    logic signed [DIN_W:0] r;

    // One guard bit keeps x + 2^(shift-1) from wrapping at the top of the range.
    always_comb begin
        x_ext = {x[DIN_W-1], x};
        bias  = '0;
        if (shift != '0) begin
            bias = (DIN_W+1)'(1) << (shift - SH_W'(1));
        end
        sum = x_ext + bias;
        r   = sum >>> shift;
        if (r > QMAX_X) begin
            q = QMAX_X[Q_W-1:0];
        end else if (r < QMIN_X) begin
            q = QMIN_X[Q_W-1:0];
        end else begin
            q = r[Q_W-1:0];
        end
    end

endmodule

// File: rtl/vq_stream_codec.sv
// Streaming block vector quantizer: load VEC_LEN samples, pick a power-of-two scale, emit codes.
// Define VQ_DEQUANT_EN to also drive dequantized samples on dq_o (tied to 0 otherwise).
module vq_stream_codec
    import vq_pkg::*;
#(
    parameter int DIN_W   = 32,
    parameter int Q_W     = 8,
    parameter int VEC_LEN = 16,
    parameter int SH_W    = sh_w_default(DIN_W)
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic signed [DIN_W-1:0] din_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic signed [Q_W-1:0]   qout_o,
    output logic        [SH_W-1:0]  shift_o,
    output logic signed [DIN_W-1:0] dq_o,
    output logic                    out_last_o,
    output logic                    done_o,
    output logic                    busy_o
);

    localparam int                IDX_W    = $clog2(VEC_LEN);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(VEC_LEN - 1);
    localparam logic [DIN_W-1:0]  QMAX_U   = DIN_W'(qmax(Q_W));

    vq_state_e state, state_nxt;

    logic        [IDX_W-1:0] idx;
    logic        [DIN_W-1:0] absmax;
    logic        [SH_W-1:0]  shift_q;
    logic                    done_q;
    logic signed [DIN_W-1:0] sample_buf [VEC_LEN];

    logic                    in_hs;
    logic                    out_hs;
    logic                    scale_more;
    logic        [DIN_W-1:0] din_mag;
    logic signed [Q_W-1:0]   code;

    assign in_hs      = in_valid_i & in_ready_o;
    assign out_hs     = out_valid_o & out_ready_i;
    // Unsigned negate makes |-2^(DIN_W-1)| come out exact.
    assign din_mag    = din_i[DIN_W-1] ? DIN_W'(-din_i) : DIN_W'(din_i);
    assign scale_more = (absmax >> shift_q) > QMAX_U;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        case (state)
            IDLE: begin
                state_nxt = LOAD;
            end
            LOAD: begin
                in_ready_o = 1'b1;
                if (in_valid_i && (idx == LAST_IDX)) begin
                    state_nxt = SCALE;
                end
            end
            SCALE: begin
                if (!scale_more) begin
                    state_nxt = EMIT;
                end
            end
            EMIT: begin
                out_valid_o = 1'b1;
                if (out_ready_i && (idx == LAST_IDX)) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            idx     <= '0;
            absmax  <= '0;
            shift_q <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                LOAD: begin
                    if (in_hs) begin
                        if (din_mag > absmax) begin
                            absmax <= din_mag;
                        end
                        idx     <= (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
                        shift_q <= '0;
                    end
                end
                SCALE: begin
                    if (scale_more) begin
                        shift_q <= shift_q + SH_W'(1);
                    end
                end
                EMIT: begin
                    if (out_hs) begin
                        if (idx == LAST_IDX) begin
                            idx    <= '0;
                            absmax <= '0;
                            done_q <= 1'b1;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Sample storage carries no reset; contents only matter after a full LOAD.
    always_ff @(posedge clk_i) begin
        if (in_hs) begin
            sample_buf[idx] <= din_i;
        end
    end

    vq_round_sat #(
        .DIN_W (DIN_W),
        .Q_W   (Q_W),
        .SH_W  (SH_W)
    ) u_round_sat (
        .x     (sample_buf[idx]),
        .shift (shift_q),
        .q     (code)
    );

    assign qout_o     = (state == EMIT) ? code : '0;
    assign shift_o    = (state == EMIT) ? shift_q : '0;
    assign out_last_o = (state == EMIT) && (idx == LAST_IDX);
    assign done_o     = done_q;
    assign busy_o     = (state != IDLE);

`ifdef VQ_DEQUANT_EN
    logic signed [DIN_W-1:0] q_ext;
    assign q_ext = {{(DIN_W-Q_W){qout_o[Q_W-1]}}, qout_o};
    assign dq_o  = q_ext <<< shift_o;
`else
    assign dq_o  = '0;
`endif

endmodule

// File: tb/tb_vq_stream_codec.sv
// Directed, table-driven bench for vq_stream_codec (DIN_W=32, Q_W=8, VEC_LEN=16).
module tb_vq_stream_codec;

    localparam int DIN_W   = 32;
    localparam int Q_W     = 8;
    localparam int VEC_LEN = 16;
    localparam int SH_W    = 6;
    localparam int NV      = 5;

    typedef struct packed {
        logic signed [DIN_W-1:0] din;
        logic signed [Q_W-1:0]   q;
    } samp_t;

    logic                    clk = 1'b0;
    logic                    rstn = 1'b0;
    logic                    in_valid = 1'b0;
    logic                    out_ready = 1'b0;
    logic signed [DIN_W-1:0] din = '0;
    logic                    in_ready;
    logic                    out_valid;
    logic signed [Q_W-1:0]   qout;
    logic        [SH_W-1:0]  shift;
    logic signed [DIN_W-1:0] dq;
    logic                    last;
    logic                    done;
    logic                    busy;

    int n_pass  = 0;
    int n_total = 0;

    samp_t tbl [NV*VEC_LEN];
    int    sh_tbl [NV] = '{0, 3, 3, 25, 0};
    logic  bp_pat [6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    int din_v [NV][VEC_LEN] = '{
        '{-127, -100, -64, -1, 0, 1, 5, 17, 33, 50, 64, 80, 99, 110, 126, 127},
        '{1000, -1000, 12, 3, 7, -4, -5, 500, -12, 100, -100, 4, 20, -20, 999, 0},
        '{1020, -1020, 1019, 1016, 0, 1, -1, 2, -2, 3, -3, 8, -8, 12, -12, 1020},
        '{32'sh8000_0000, 2147483647, 33554432, 16777216, 16777215, -16777216, -16777217, 0,
          100663296, -100663296, 2113929216, -2113929216, 1, -1, 1000, 32'sh8000_0000},
        '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}
    };

    int q_v [NV][VEC_LEN] = '{
        '{-127, -100, -64, -1, 0, 1, 5, 17, 33, 50, 64, 80, 99, 110, 126, 127},
        '{125, -125, 2, 0, 1, 0, -1, 63, -1, 13, -12, 1, 3, -2, 125, 0},
        '{127, -127, 127, 127, 0, 0, 0, 0, 0, 0, 0, 1, -1, 2, -1, 127},
        '{-64, 64, 1, 1, 0, 0, -1, 0, 3, -3, 63, -63, 0, 0, 0, -64},
        '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}
    };

    vq_stream_codec #(
        .DIN_W   (DIN_W),
        .Q_W     (Q_W),
        .VEC_LEN (VEC_LEN),
        .SH_W    (SH_W)
    ) dut (
        .clk_i       (clk),
        .rstn_i      (rstn),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .din_i       (din),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .qout_o      (qout),
        .shift_o     (shift),
        .dq_o        (dq),
        .out_last_o  (last),
        .done_o      (done),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_in_ready"}, longint'(in_ready), 0);
        chk({tag, "_out_valid"}, longint'(out_valid), 0);
        chk({tag, "_qout"}, longint'(qout), 0);
        chk({tag, "_shift"}, longint'(shift), 0);
        chk({tag, "_dq"}, longint'(dq), 0);
        chk({tag, "_last"}, longint'(last), 0);
        chk({tag, "_done"}, longint'(done), 0);
        chk({tag, "_busy"}, longint'(busy), 0);
    endtask

    // Present n samples of vector v; handshake is decided at the negedge before the posedge.
    task automatic load_vec(input int v, input int n, input bit gaps);
        int i = 0;
        int guard = 0;
        while (i < n && guard < 400) begin
            @(negedge clk);
            guard++;
            if (in_ready) chk("in_ready_not_emit", longint'(out_valid), 0);
            if (gaps && ($urandom_range(0, 2) == 0)) begin
                in_valid = 1'b0;
            end else begin
                in_valid = 1'b1;
                din      = tbl[v*VEC_LEN + i].din;
            end
            if (in_valid && in_ready) i++;
        end
        chk($sformatf("v%0d_load_count", v), longint'(i), longint'(n));
    endtask

    task automatic emit_vec(input int v, input bit bp);
        int i = 0;
        int guard = 0;
        int pc = 0;
        bit stalled = 1'b0;
        logic signed [Q_W-1:0]   hq = '0;
        logic        [SH_W-1:0]  hs = '0;
        logic                    hl = 1'b0;
        logic signed [Q_W-1:0]   qe;
        logic signed [DIN_W-1:0] dq_exp;
        while (i < VEC_LEN && guard < 2000) begin
            @(negedge clk);
            guard++;
            if (stalled) begin
                chk("hold_valid", longint'(out_valid), 1);
                chk("hold_q", longint'(qout), longint'(hq));
                chk("hold_shift", longint'(shift), longint'(hs));
                chk("hold_last", longint'(last), longint'(hl));
            end
            out_ready = bp ? bp_pat[pc % 6] : 1'b1;
            pc++;
            stalled = 1'b0;
            if (out_valid) begin
                if (out_ready) begin
                    qe = tbl[v*VEC_LEN + i].q;
                    chk($sformatf("v%0d_q%0d", v, i), longint'(qout), longint'(qe));
                    chk($sformatf("v%0d_shift%0d", v, i), longint'(shift), longint'(sh_tbl[v]));
                    chk($sformatf("v%0d_last%0d", v, i), longint'(last), (i == VEC_LEN-1) ? 1 : 0);
                    chk("in_ready_in_emit", longint'(in_ready), 0);
                    chk("no_early_done", longint'(done), 0);
`ifdef VQ_DEQUANT_EN
                    dq_exp = {{(DIN_W-Q_W){qe[Q_W-1]}}, qe};
                    dq_exp = dq_exp <<< sh_tbl[v];
`else
                    dq_exp = '0;
`endif
                    chk($sformatf("v%0d_dq%0d", v, i), longint'(dq), longint'(dq_exp));
                    i++;
                end else begin
                    stalled = 1'b1;
                    hq = qout;
                    hs = shift;
                    hl = last;
                end
            end
        end
        chk($sformatf("v%0d_emit_count", v), longint'(i), VEC_LEN);
        @(negedge clk);
        out_ready = 1'b0;
        chk("done_pulse", longint'(done), 1);
        chk("valid_after_last", longint'(out_valid), 0);
        chk("busy_idle", longint'(busy), 0);
        @(negedge clk);
        chk("done_clear", longint'(done), 0);
        chk("busy_load", longint'(busy), 1);
    endtask

    task automatic run_vec(input int v, input bit gaps, input bit bp);
        load_vec(v, VEC_LEN, gaps);
        @(negedge clk);
        in_valid = 1'b0;
        chk("in_ready_after_load", longint'(in_ready), 0);
        emit_vec(v, bp);
    endtask

    initial begin
        for (int v = 0; v < NV; v++) begin
            for (int i = 0; i < VEC_LEN; i++) begin
                tbl[v*VEC_LEN + i].din = din_v[v][i];
                tbl[v*VEC_LEN + i].q   = Q_W'(q_v[v][i]);
            end
        end

        #1;
        chk_all_zero("reset");
        #20;
        @(negedge clk);
        rstn = 1'b1;

        run_vec(0, 1'b0, 1'b0);
        run_vec(1, 1'b0, 1'b1);
        run_vec(2, 1'b1, 1'b0);
        run_vec(3, 1'b0, 1'b1);
        run_vec(4, 1'b1, 1'b1);

        // Partial vector discarded by an asynchronous reset
        load_vec(3, 7, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        chk("pre_reset_busy", longint'(busy), 1);
        rstn = 1'b0;
        #1;
        chk_all_zero("midreset");
        repeat (3) begin
            @(negedge clk);
            chk("midreset_no_done", longint'(done), 0);
        end
        rstn = 1'b1;
        run_vec(1, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
